// File: rtl/display_formatter_pkg.sv
// Shared constants, state encoding and the double-dabble helper for the
// display formatter.
package display_formatter_pkg;

  typedef enum logic [1:0] {StIdle, StConvert, StFormat} state_e;

  // Active-low patterns, bits [7:1] = segments a..g, bit 0 = dp; index = nibble value.
  localparam logic [15:0][7:0] DigitCodes = {
    8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };

  localparam logic [7:0]  Blank      = 8'hFF;
  localparam logic [7:0]  Dash       = 8'hFD;
  localparam logic [15:0] DecMax     = 16'd9999;
  localparam logic [4:0]  ConvCycles = 5'd16;

  function automatic logic [15:0] dd_adjust(input logic [15:0] bcd);
    logic [15:0] r;
    r = bcd;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/display_formatter_if.sv
// Request/result bundle between a display client (master) and the formatter (slave).
interface display_formatter_if;
  logic [15:0] binIn;
  logic        load;
  logic        hexMode;
  logic        blankZeros;
  logic [3:0]  dpIn;
  logic [7:0]  displayValuesA;
  logic [7:0]  displayValuesB;
  logic [7:0]  displayValuesC;
  logic [7:0]  displayValuesD;
  logic        busy;
  logic        done;

  modport master (
    output binIn, load, hexMode, blankZeros, dpIn,
    input  displayValuesA, displayValuesB, displayValuesC, displayValuesD, busy, done
  );

  modport slave (
    input  binIn, load, hexMode, blankZeros, dpIn,
    output displayValuesA, displayValuesB, displayValuesC, displayValuesD, busy, done
  );
endinterface

// File: rtl/seg_encoder.sv
// Nibble to active-low seven-segment pattern; dash overrides blank, dp applies to all.
module seg_encoder
  import display_formatter_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  input  logic       dash_i,
  input  logic       dp_i,
  output logic [7:0] pattern_o
);

  always_comb begin
    if (dash_i) begin
      pattern_o = Dash;
    end else if (blank_i) begin
      pattern_o = Blank;
    end else begin
      pattern_o = DigitCodes[nibble_i];
    end
    if (dp_i) pattern_o[0] = 1'b0;
  end

endmodule

// File: rtl/display_formatter.sv
// Formats a 16-bit operand as four hex or decimal seven-segment patterns, with
// leading-zero blanking, decimal points and a dash display for decimal overflow.
module display_formatter
  import display_formatter_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  display_formatter_if.slave  bus
);

  state_e           state_q, state_d;
  logic [15:0]      shift_q, shift_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             hex_q, hex_d;
  logic             blank_q, blank_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       dp_q, dp_d;
  logic [3:0][7:0]  disp_q, disp_d;
  logic             done_q, done_d;

  logic [3:0][3:0]  digits;
  logic [3:0]       blank;
  logic             dash;
  logic [3:0][7:0]  pattern;

  // Hex digits come straight from the untouched operand; decimal from the BCD result.
  always_comb begin
    digits   = hex_q ? shift_q : bcd_q;
    dash     = ovf_q & ~hex_q;
    blank[3] = blank_q & ~dash & (digits[3] == 4'd0);
    blank[2] = blank[3] & (digits[2] == 4'd0);
    blank[1] = blank[2] & (digits[1] == 4'd0);
    blank[0] = 1'b0;
  end

  for (genvar i = 0; i < 4; i++) begin : g_seg
    seg_encoder u_seg (
      .nibble_i  (digits[i]),
      .blank_i   (blank[i]),
      .dash_i    (dash),
      .dp_i      (dp_q[i]),
      .pattern_o (pattern[i])
    );
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    blank_d = blank_q;
    ovf_d   = ovf_q;
    dp_d    = dp_q;
    disp_d  = disp_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.load) begin
          shift_d = bus.binIn;
          bcd_d   = '0;
          cnt_d   = '0;
          hex_d   = bus.hexMode;
          blank_d = bus.blankZeros;
          ovf_d   = bus.binIn > DecMax;
          dp_d    = bus.dpIn;
          state_d = bus.hexMode ? StFormat : StConvert;
        end
      end
      StConvert: begin
        bcd_d   = {dd_adjust(bcd_q)[14:0], shift_q[15]};
        shift_d = {shift_q[14:0], 1'b0};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == ConvCycles - 5'd1) state_d = StFormat;
      end
      StFormat: begin
        disp_d  = pattern;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= 1'b0;
      blank_q <= 1'b0;
      ovf_q   <= 1'b0;
      dp_q    <= '0;
      disp_q  <= {4{Blank}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
      dp_q    <= dp_d;
      disp_q  <= disp_d;
      done_q  <= done_d;
    end
  end

  assign bus.displayValuesA = disp_q[3];
  assign bus.displayValuesB = disp_q[2];
  assign bus.displayValuesC = disp_q[1];
  assign bus.displayValuesD = disp_q[0];
  assign bus.busy           = (state_q != StIdle);
  assign bus.done           = done_q;

endmodule
